// File: rtl/basic_types_pkg.sv
// Basic types shared across the pipeline.
//   IId : instruction id carried alongside every in-flight instruction.
package basic_types_pkg;

  typedef logic [7:0] IId;

endpackage

// File: rtl/mem_stage_pkg.sv
// Types and helpers for the memory-access pipeline stage.
//   mem_op_e    : memory operation carried by an instruction (none/load/store)
//   mem_size_e  : access size, log2 of the byte count (B/H/W/D)
//   mem_state_e : control FSM states of mem_stage
//   is_misaligned() : alignment check for an access of a given size
package pkg_memstage;

  typedef enum logic [1:0] {
    MemOpNone  = 2'd0,
    MemOpLoad  = 2'd1,
    MemOpStore = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MemSizeB = 2'd0,
    MemSizeH = 2'd1,
    MemSizeW = 2'd2,
    MemSizeD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } mem_state_e;

  // A doubleword access can never be satisfied on a 32-bit datapath, so it
  // is reported as misaligned regardless of address.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_e size,
                                         input int unsigned xlen);
    logic mis;
    mis = 1'b0;
    case (size)
      MemSizeB: mis = 1'b0;
      MemSizeH: mis = addr_lo[0];
      MemSizeW: mis = (addr_lo[1:0] != 2'b00);
      MemSizeD: mis = (xlen == 32) || (addr_lo != 3'b000);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage.
//   request : mem_req_valid/mem_req_ready handshake carrying a word-aligned
//             address, write enable, lane-shifted write data and byte mask
//   response: mem_resp_valid qualifies a full memory word (no back-pressure)
// Modports: master = pipeline stage side, slave = memory side.
interface mem_stage_if #(
  parameter int unsigned XLEN = 32
) ();

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [XLEN-1:0]       mem_req_addr;
  logic                  mem_req_wen;
  logic [XLEN-1:0]       mem_req_wdata;
  logic [XLEN/8-1:0]     mem_req_wmask;
  logic                  mem_resp_valid;
  logic [XLEN-1:0]       mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/mem_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
//   off_i        : byte offset of the access within the memory word
//   size_i       : access size
//   unsigned_i   : zero-extend (1) or sign-extend (0) load data
//   store_data_i : right-aligned store data
//   rdata_i      : full memory word returned for a load
//   wmask_o      : byte enables of the store
//   wdata_o      : store data shifted onto its byte lanes
//   load_data_o  : load data extracted, truncated and extended to XLEN
module mem_lane_align
  import pkg_memstage::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  mem_size_e                 size_i,
  input  logic                      unsigned_i,
  input  logic [XLEN-1:0]           store_data_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN/8-1:0]         wmask_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           load_data_o
);

  localparam int unsigned Lanes = XLEN / 8;

  logic [Lanes-1:0] mask_base;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  left;
  int unsigned      bits;
  int unsigned      sh;

  always_comb begin
    mask_base = '0;
    case (size_i)
      MemSizeB: mask_base = Lanes'(1);
      MemSizeH: mask_base = Lanes'(3);
      MemSizeW: mask_base = Lanes'(15);
      MemSizeD: mask_base = '1;
      default:  mask_base = '0;
    endcase
    wmask_o = mask_base << off_i;
    wdata_o = store_data_i << {off_i, 3'b000};
  end

  // Extension trick: move the selected field to the top of the word, then
  // shift back down logically (zero-extend) or arithmetically (sign-extend).
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    bits    = 32'd8 << size_i;
    if (bits > XLEN) begin
      bits = XLEN;
    end
    sh   = XLEN - bits;
    left = shifted << sh;
    if (unsigned_i) begin
      load_data_o = left >> sh;
    end else begin
      load_data_o = XLEN'($signed(left) >>> sh);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage sitting directly upstream of write-back.
// Takes one execute-stage bundle at a time, performs its data-memory access
// (if any) and emits a one-cycle write-back bundle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_*_i / in_ready_o : execute-stage bundle, valid/ready accepted
//   mem               : data-memory port (mem_stage_if master modport)
//   out_*_o           : write-back bundle, out_valid_o pulses once per instruction
//   out_misaligned_o  : instruction was squashed for a misaligned access
// Optional: define MEMSTAGE_PERF_EN to add 64-bit perf_load_cnt_o,
// perf_store_cnt_o and perf_stall_cycles_o counters.
// XLEN must be 32 or 64.
module mem_stage
  import pkg_memstage::*;
  import basic_types_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // Execute-stage bundle
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [31:0]     in_inst_i,
  input  IId              in_inst_id_i,
  input  logic            in_rf_wen_i,
  input  logic [4:0]      in_reg_addr_i,
  input  logic [XLEN-1:0] in_alu_result_i,
  input  mem_op_e         in_mem_op_i,
  input  mem_size_e       in_mem_size_i,
  input  logic            in_mem_unsigned_i,
  input  logic [XLEN-1:0] in_store_data_i,
  // Data memory
  mem_stage_if.master     mem,
  // Write-back bundle
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_inst_o,
  output IId              out_inst_id_o,
  output logic            out_rf_wen_o,
  output logic [4:0]      out_reg_addr_o,
  output logic [XLEN-1:0] out_wdata_o,
  output logic            out_misaligned_o
`ifdef MEMSTAGE_PERF_EN
  ,
  output logic [63:0]     perf_load_cnt_o,
  output logic [63:0]     perf_store_cnt_o,
  output logic [63:0]     perf_stall_cycles_o
`endif
);

  localparam int unsigned Lanes = XLEN / 8;
  localparam int unsigned OffW  = $clog2(Lanes);

  mem_state_e state_q;

  // Holding register for the accepted bundle
  logic [XLEN-1:0] hold_pc_q;
  logic [31:0]     hold_inst_q;
  IId              hold_id_q;
  logic            hold_rf_wen_q;
  logic [4:0]      hold_reg_q;
  logic [XLEN-1:0] hold_addr_q;
  mem_op_e         hold_op_q;
  mem_size_e       hold_size_q;
  logic            hold_uns_q;
  logic [XLEN-1:0] hold_sdata_q;

  // Registered write-back bundle
  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_inst_q;
  IId              out_id_q;
  logic            out_rf_wen_q;
  logic [4:0]      out_reg_q;
  logic [XLEN-1:0] out_wdata_q;
  logic            out_mis_q;

  logic             in_misaligned;
  logic             req_fire;
  logic [Lanes-1:0] align_wmask;
  logic [XLEN-1:0]  align_wdata;
  logic [XLEN-1:0]  align_load;

  assign in_ready_o    = (state_q == StIdle);
  assign in_misaligned = is_misaligned(in_alu_result_i[2:0], in_mem_size_i, XLEN);
  assign req_fire      = (state_q == StReq) && mem.mem_req_ready;

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .off_i       (hold_addr_q[OffW-1:0]),
    .size_i      (hold_size_q),
    .unsigned_i  (hold_uns_q),
    .store_data_i(hold_sdata_q),
    .rdata_i     (mem.mem_resp_rdata),
    .wmask_o     (align_wmask),
    .wdata_o     (align_wdata),
    .load_data_o (align_load)
  );

  // Request fields come straight from the holding register, so they stay
  // stable for as long as the request waits for ready. Outside StReq they
  // are driven to zero.
  always_comb begin
    mem.mem_req_valid = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wen   = 1'b0;
    mem.mem_req_wdata = '0;
    mem.mem_req_wmask = '0;
    if (state_q == StReq) begin
      mem.mem_req_valid = 1'b1;
      mem.mem_req_addr  = {hold_addr_q[XLEN-1:OffW], {OffW{1'b0}}};
      mem.mem_req_wen   = (hold_op_q == MemOpStore);
      mem.mem_req_wdata = align_wdata;
      mem.mem_req_wmask = align_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_pc_q     <= '0;
      hold_inst_q   <= '0;
      hold_id_q     <= '0;
      hold_rf_wen_q <= 1'b0;
      hold_reg_q    <= '0;
      hold_addr_q   <= '0;
      hold_op_q     <= MemOpNone;
      hold_size_q   <= MemSizeB;
      hold_uns_q    <= 1'b0;
      hold_sdata_q  <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_id_q      <= '0;
      out_rf_wen_q  <= 1'b0;
      out_reg_q     <= '0;
      out_wdata_q   <= '0;
      out_mis_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            hold_pc_q     <= in_pc_i;
            hold_inst_q   <= in_inst_i;
            hold_id_q     <= in_inst_id_i;
            hold_rf_wen_q <= in_rf_wen_i;
            hold_reg_q    <= in_reg_addr_i;
            hold_addr_q   <= in_alu_result_i;
            hold_op_q     <= in_mem_op_i;
            hold_size_q   <= in_mem_size_i;
            hold_uns_q    <= in_mem_unsigned_i;
            hold_sdata_q  <= in_store_data_i;
            if (in_mem_op_i == MemOpNone || in_misaligned) begin
              // Completes without touching memory
              out_valid_q <= 1'b1;
              out_pc_q    <= in_pc_i;
              out_inst_q  <= in_inst_i;
              out_id_q    <= in_inst_id_i;
              out_reg_q   <= in_reg_addr_i;
              out_wdata_q <= in_alu_result_i;
              if (in_mem_op_i == MemOpNone) begin
                out_rf_wen_q <= in_rf_wen_i && (in_reg_addr_i != 5'd0);
                out_mis_q    <= 1'b0;
              end else begin
                out_rf_wen_q <= 1'b0;
                out_mis_q    <= 1'b1;
              end
            end else begin
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          if (mem.mem_req_ready) begin
            if (hold_op_q == MemOpStore) begin
              out_valid_q  <= 1'b1;
              out_pc_q     <= hold_pc_q;
              out_inst_q   <= hold_inst_q;
              out_id_q     <= hold_id_q;
              out_reg_q    <= hold_reg_q;
              out_wdata_q  <= hold_addr_q;
              out_rf_wen_q <= 1'b0;
              out_mis_q    <= 1'b0;
              state_q      <= StIdle;
            end else begin
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          if (mem.mem_resp_valid) begin
            out_valid_q  <= 1'b1;
            out_pc_q     <= hold_pc_q;
            out_inst_q   <= hold_inst_q;
            out_id_q     <= hold_id_q;
            out_reg_q    <= hold_reg_q;
            out_wdata_q  <= align_load;
            out_rf_wen_q <= hold_rf_wen_q && (hold_reg_q != 5'd0);
            out_mis_q    <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_pc_o         = out_pc_q;
  assign out_inst_o       = out_inst_q;
  assign out_inst_id_o    = out_id_q;
  assign out_rf_wen_o     = out_rf_wen_q;
  assign out_reg_addr_o   = out_reg_q;
  assign out_wdata_o      = out_wdata_q;
  assign out_misaligned_o = out_mis_q;

`ifdef MEMSTAGE_PERF_EN
  logic [63:0] perf_load_q;
  logic [63:0] perf_store_q;
  logic [63:0] perf_stall_q;

  // Loads and stores are counted when their request is accepted by memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_q  <= '0;
      perf_store_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (req_fire && hold_op_q == MemOpLoad) begin
        perf_load_q <= perf_load_q + 64'd1;
      end
      if (req_fire && hold_op_q == MemOpStore) begin
        perf_store_q <= perf_store_q + 64'd1;
      end
      if (state_q != StIdle) begin
        perf_stall_q <= perf_stall_q + 64'd1;
      end
    end
  end

  assign perf_load_cnt_o     = perf_load_q;
  assign perf_store_cnt_o    = perf_store_q;
  assign perf_stall_cycles_o = perf_stall_q;
`else
  logic unused_req_fire;
  assign unused_req_fire = req_fire;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import pkg_memstage::*;
  import basic_types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  IId          in_inst_id;
  logic        in_rf_wen;
  logic [4:0]  in_reg_addr;
  logic [31:0] in_alu_result;
  mem_op_e     in_mem_op;
  mem_size_e   in_mem_size;
  logic        in_mem_unsigned;
  logic [31:0] in_store_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  IId          out_inst_id;
  logic        out_rf_wen;
  logic [4:0]  out_reg_addr;
  logic [31:0] out_wdata;
  logic        out_misaligned;
`ifdef MEMSTAGE_PERF_EN
  logic [63:0] perf_load_cnt;
  logic [63:0] perf_store_cnt;
  logic [63:0] perf_stall_cycles;
`endif

  mem_stage_if #(.XLEN(32)) mem_bus ();

  mem_stage #(
    .XLEN(32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_pc_i          (in_pc),
    .in_inst_i        (in_inst),
    .in_inst_id_i     (in_inst_id),
    .in_rf_wen_i      (in_rf_wen),
    .in_reg_addr_i    (in_reg_addr),
    .in_alu_result_i  (in_alu_result),
    .in_mem_op_i      (in_mem_op),
    .in_mem_size_i    (in_mem_size),
    .in_mem_unsigned_i(in_mem_unsigned),
    .in_store_data_i  (in_store_data),
    .mem              (mem_bus),
    .out_valid_o      (out_valid),
    .out_pc_o         (out_pc),
    .out_inst_o       (out_inst),
    .out_inst_id_o    (out_inst_id),
    .out_rf_wen_o     (out_rf_wen),
    .out_reg_addr_o   (out_reg_addr),
    .out_wdata_o      (out_wdata),
    .out_misaligned_o (out_misaligned)
`ifdef MEMSTAGE_PERF_EN
    ,
    .perf_load_cnt_o    (perf_load_cnt),
    .perf_store_cnt_o   (perf_store_cnt),
    .perf_stall_cycles_o(perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    mem_op_e     op;
    mem_size_e   size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rf_wen;
    // expected
    logic        has_req;
    logic [31:0] e_req_addr;
    logic [3:0]  e_wmask;
    logic [31:0] e_req_wdata;
    logic        e_mis;
    logic        e_chk_wdata;
    logic [31:0] e_wdata;
    logic        e_rf_wen;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bundle(input mem_op_e op, input mem_size_e size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic rf_wen,
                              input logic [31:0] pc, input logic [7:0] id);
    in_valid        = 1'b1;
    in_pc           = pc;
    in_inst         = 32'h0000_0013 ^ {pc[15:0], 16'h0};
    in_inst_id      = id;
    in_rf_wen       = rf_wen;
    in_reg_addr     = rd;
    in_alu_result   = addr;
    in_mem_op       = op;
    in_mem_size     = size;
    in_mem_unsigned = uns;
    in_store_data   = sdata;
  endtask

  task automatic check_out(input vec_t v, input logic [31:0] pc, input logic [7:0] id);
    check({v.name, ".out_valid"}, 64'(out_valid), 64'd1);
    check({v.name, ".out_pc"}, 64'(out_pc), 64'(pc));
    check({v.name, ".out_inst_id"}, 64'(out_inst_id), 64'(id));
    check({v.name, ".out_reg_addr"}, 64'(out_reg_addr), 64'(v.rd));
    check({v.name, ".out_rf_wen"}, 64'(out_rf_wen), 64'(v.e_rf_wen));
    check({v.name, ".out_misaligned"}, 64'(out_misaligned), 64'(v.e_mis));
    if (v.e_chk_wdata) check({v.name, ".out_wdata"}, 64'(out_wdata), 64'(v.e_wdata));
    check({v.name, ".in_ready_at_out"}, 64'(in_ready), 64'd1);
  endtask

  task automatic apply_vec(input vec_t v, input logic [31:0] pc, input logic [7:0] id);
    drive_bundle(v.op, v.size, v.uns, v.addr, v.sdata, v.rd, v.rf_wen, pc, id);
    check({v.name, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    if (!v.has_req) begin
      check({v.name, ".no_req"}, 64'(mem_bus.mem_req_valid), 64'd0);
      check_out(v, pc, id);
    end else begin
      check({v.name, ".req_valid"}, 64'(mem_bus.mem_req_valid), 64'd1);
      check({v.name, ".req_addr"}, 64'(mem_bus.mem_req_addr), 64'(v.e_req_addr));
      check({v.name, ".req_wen"}, 64'(mem_bus.mem_req_wen), 64'(v.op == MemOpStore));
      if (v.op == MemOpStore) begin
        check({v.name, ".req_wmask"}, 64'(mem_bus.mem_req_wmask), 64'(v.e_wmask));
        check({v.name, ".req_wdata"}, 64'(mem_bus.mem_req_wdata), 64'(v.e_req_wdata));
      end
      check({v.name, ".busy_no_out"}, 64'(out_valid), 64'd0);
      tick();
      if (v.op == MemOpLoad) begin
        check({v.name, ".resp_wait_no_out"}, 64'(out_valid), 64'd0);
        check({v.name, ".resp_wait_no_req"}, 64'(mem_bus.mem_req_valid), 64'd0);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = v.rdata;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = 32'h0;
      end
      check_out(v, pc, id);
    end
    tick();
    check({v.name, ".pulse_end"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    // name op size uns addr sdata rdata rd rf | req raddr wmask rwdata mis chk wdata rf
    vecs.push_back('{"nop", MemOpNone, MemSizeW, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b1});
    vecs.push_back('{"lb", MemOpLoad, MemSizeB, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 5'd8,
                     1'b1, 1'b1, 32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1});
    vecs.push_back('{"lbu", MemOpLoad, MemSizeB, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 5'd8,
                     1'b1, 1'b1, 32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 1'b1});
    vecs.push_back('{"sh", MemOpStore, MemSizeH, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 5'd9,
                     1'b0, 1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"lw_mis", MemOpLoad, MemSizeW, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 5'd6, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"lh", MemOpLoad, MemSizeH, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_1234, 5'd10,
                     1'b1, 1'b1, 32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1});
    vecs.push_back('{"lhu", MemOpLoad, MemSizeH, 1'b1, 32'h0000_1002, 32'h0, 32'h8001_1234, 5'd10,
                     1'b1, 1'b1, 32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1'b1});
    vecs.push_back('{"lw", MemOpLoad, MemSizeW, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 5'd11,
                     1'b1, 1'b1, 32'h0000_1004, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1});
    vecs.push_back('{"lb_off1", MemOpLoad, MemSizeB, 1'b0, 32'h0000_1001, 32'h0, 32'h0000_F00F,
                     5'd12, 1'b1, 1'b1, 32'h0000_1000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0,
                     1'b1});
    vecs.push_back('{"sb", MemOpStore, MemSizeB, 1'b0, 32'h0000_3001, 32'h1234_56AB, 32'h0, 5'd0,
                     1'b0, 1'b1, 32'h0000_3000, 4'b0010, 32'h3456_AB00, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"sw", MemOpStore, MemSizeW, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 5'd0,
                     1'b0, 1'b1, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"sd_mis", MemOpStore, MemSizeD, 1'b0, 32'h0000_3000, 32'h1, 32'h0, 5'd0, 1'b0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"sh_mis", MemOpStore, MemSizeH, 1'b0, 32'h0000_2001, 32'h1, 32'h0, 5'd0, 1'b0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{"nop_r0", MemOpNone, MemSizeW, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0055, 1'b0});
    vecs.push_back('{"lb_r0", MemOpLoad, MemSizeB, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_007F, 5'd0,
                     1'b1, 1'b1, 32'h0000_0010, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_007F, 1'b0});

    rst_n                  = 1'b0;
    in_valid               = 1'b0;
    in_pc                  = '0;
    in_inst                = '0;
    in_inst_id             = '0;
    in_rf_wen              = 1'b0;
    in_reg_addr            = '0;
    in_alu_result          = '0;
    in_mem_op              = MemOpNone;
    in_mem_size            = MemSizeB;
    in_mem_unsigned        = 1'b0;
    in_store_data          = '0;
    mem_bus.mem_req_ready  = 1'b1;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
    check("rst.out_rf_wen", 64'(out_rf_wen), 64'd0);
    check("rst.out_misaligned", 64'(out_misaligned), 64'd0);
    check("rst.req_addr", 64'(mem_bus.mem_req_addr), 64'd0);
    check("rst.out_wdata", 64'(out_wdata), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], 32'h0000_0100 + 32'(i) * 4, 8'(i + 1));
    end

    // Back-to-back: a new bundle is accepted in the cycle out_valid is high
    drive_bundle(MemOpNone, MemSizeW, 1'b0, 32'h0000_0AAA, 32'h0, 5'd3, 1'b1, 32'h200, 8'h40);
    tick();
    check("b2b.first_valid", 64'(out_valid), 64'd1);
    check("b2b.in_ready", 64'(in_ready), 64'd1);
    drive_bundle(MemOpNone, MemSizeW, 1'b0, 32'h0000_0BBB, 32'h0, 5'd4, 1'b1, 32'h204, 8'h41);
    tick();
    in_valid = 1'b0;
    check("b2b.second_valid", 64'(out_valid), 64'd1);
    check("b2b.second_wdata", 64'(out_wdata), 64'h0BBB);
    check("b2b.second_reg", 64'(out_reg_addr), 64'd4);
    tick();
    check("b2b.pulse_end", 64'(out_valid), 64'd0);

    // Memory holds off ready for 3 cycles on a store
    mem_bus.mem_req_ready = 1'b0;
    drive_bundle(MemOpStore, MemSizeW, 1'b0, 32'h0000_4000, 32'h1122_3344, 5'd0, 1'b0,
                 32'h300, 8'h50);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("stall.req_valid", 64'(mem_bus.mem_req_valid), 64'd1);
      check("stall.req_addr", 64'(mem_bus.mem_req_addr), 64'h4000);
      check("stall.req_wdata", 64'(mem_bus.mem_req_wdata), 64'h1122_3344);
      check("stall.req_wmask", 64'(mem_bus.mem_req_wmask), 64'hF);
      check("stall.req_wen", 64'(mem_bus.mem_req_wen), 64'd1);
      check("stall.in_ready", 64'(in_ready), 64'd0);
      check("stall.no_out", 64'(out_valid), 64'd0);
      tick();
    end
    mem_bus.mem_req_ready = 1'b1;
    tick();
    check("stall.done_valid", 64'(out_valid), 64'd1);
    check("stall.done_rf_wen", 64'(out_rf_wen), 64'd0);
    check("stall.done_pc", 64'(out_pc), 64'h300);
    check("stall.req_dropped", 64'(mem_bus.mem_req_valid), 64'd0);
    tick();
    check("stall.pulse_end", 64'(out_valid), 64'd0);

    // Asynchronous reset while waiting for a load response
    drive_bundle(MemOpLoad, MemSizeW, 1'b0, 32'h0000_5000, 32'h0, 5'd7, 1'b1, 32'h400, 8'h60);
    tick();
    in_valid = 1'b0;
    check("rstresp.req_valid", 64'(mem_bus.mem_req_valid), 64'd1);
    tick();
    check("rstresp.in_resp", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rstresp.out_valid", 64'(out_valid), 64'd0);
    check("rstresp.req_valid_low", 64'(mem_bus.mem_req_valid), 64'd0);
    check("rstresp.idle", 64'(in_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_rdata = 32'h1357_9BDF;
    tick();
    mem_bus.mem_resp_valid = 1'b0;
    check("rstresp.late_resp_ignored", 64'(out_valid), 64'd0);
    check("rstresp.still_idle", 64'(in_ready), 64'd1);
    tick();
    check("rstresp.no_late_out", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly upstream of the write-back stage.
- Accepts one instruction at a time from the execute stage and performs its data-memory access, if any, over a valid/ready request, valid-response port.
- Aligns and extends load data, then presents a single-cycle valid bundle (pc, inst, inst_id, rf_wen, reg_addr, wdata) to write-back.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- LANES, XLEN/8, byte lanes per memory word; derived, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute-stage bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_pc  in  XLEN  instruction address
- in_inst  in  32  instruction word
- in_inst_id  in  IId  instruction id
- in_rf_wen  in  1  instruction writes a register
- in_reg_addr  in  5  destination register
- in_alu_result  in  XLEN  ALU result; effective address for memory ops
- in_mem_op  in  MemOp  NONE/LOAD/STORE
- in_mem_size  in  MemSize  B/H/W/D
- in_mem_unsigned  in  1  zero-extend load
- in_store_data  in  XLEN  store data, right-aligned
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address
- mem_req_wen  out  1  store
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wmask  out  LANES  byte enables
- mem_resp_valid  in  1  load data valid
- mem_resp_rdata  in  XLEN  full memory word
- out_valid  out  1  write-back bundle valid, 1-cycle pulse
- out_pc, out_inst, out_inst_id, out_rf_wen, out_reg_addr, out_wdata  out  as inputs  write-back bundle
- out_misaligned  out  1  access was misaligned; instruction squashed

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, mem_req_valid, out_rf_wen, out_misaligned=0; all other outputs 0. Takes effect immediately, including mid-access.
- in_ready = (state==IDLE). A bundle is accepted on in_valid & in_ready and captured into a holding register.
- FSM states and transitions:
  - IDLE, on accept:
    - mem_op=NONE: next cycle out_valid=1, wdata=alu_result; stay IDLE.
    - Misaligned access (addr mod 2^size ≠ 0, or size=D when XLEN=32): no request; next cycle out_valid=1, out_misaligned=1, out_rf_wen=0.
    - Otherwise: go to REQ.
  - REQ:
    - mem_req_valid=1; addr, wen, wdata and wmask are held stable until mem_req_ready.
    - Handshake completes on valid&ready. Store: next cycle out_valid=1, out_rf_wen=0, go IDLE. Load: go to RESP.
  - RESP:
    - mem_req_valid=0. On mem_resp_valid, register the extended data; next cycle out_valid=1, go IDLE.
    - mem_resp_valid is ignored in IDLE and REQ.
- Output timing: out_valid is high for exactly one cycle per instruction. The stage can accept a new bundle in the same cycle out_valid is high.
- Latency: non-memory and misaligned instructions take 1 cycle; a store takes 1 + ready-wait + 1; a load takes 1 + ready-wait + response-wait + 1.
- Lane rules: off = addr[log2(LANES)-1:0]; wmask = ((1<<2^size)-1) << off; wdata = store_data << (8*off); load = (rdata >> 8*off), truncated to the size, then sign- or zero-extended to XLEN.
- out_rf_wen is forced to 0 when reg_addr==0.

Optional Feature:
- MEMSTAGE_PERF_EN defined: adds 64-bit outputs perf_load_cnt, perf_store_cnt and perf_stall_cycles. perf_stall_cycles counts cycles with state≠IDLE. All three reset to 0 and wrap at 2^64.
- MEMSTAGE_PERF_EN undefined: the ports and counters do not exist.

Decomposition:
- Package pkg_memstage holds: MemOp enum (NONE=0, LOAD=1, STORE=2), MemSize enum (B=0, H=1, W=2, D=3), and the state enum.
- IId comes from the existing basic-types package.
- Sub-module mem_lane_align (combinational): wmask/wdata generation and load extract/extend. Verified standalone.

Test Plan (XLEN=32):
- Non-memory op, alu_result=0x00001234, reg 5 -> next cycle out_valid=1, wdata=0x00001234, reg_addr=5, rf_wen=1.
- LB, addr 0x1003, rdata 0x80FFFFFF -> mem_req_addr=0x1000, wdata=0xFFFFFF80. Same with in_mem_unsigned=1 -> 0x00000080.
- SH, addr 0x2002, data 0x0000ABCD -> wmask=4'b1100, mem_req_wdata=0xABCD0000, mem_req_wen=1; out_valid with rf_wen=0.
- mem_req_ready low 3 cycles -> request fields stable all 3 cycles, in_ready=0, no out_valid; completes the cycle after ready rises.
- LW at 0x1002 -> no mem_req_valid; next cycle out_valid=1, out_misaligned=1, rf_wen=0.
- rst_n low while in RESP -> out_valid and mem_req_valid=0 immediately, state IDLE; a mem_resp_valid arriving after reset produces no out_valid.
